specdrum_multi: RTL and testbench

Multi-channel, parametrised successor to the single-port 8-bit write-only DAC latch. Decodes Z80 I/O writes to a contiguous block of channel ports and either latches each byte straight to its channel output (direct mode) or queues it in a per-channel FIFO that is drained at a fixed sample rate (paced mode). A status/control port selects the mode and reports FIFO state. Outputs feed the audio mixer.

---
 rtl/specdrum_multi.sv | 159 +++++++++++++++
 tb/tb_specdrum_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/specdrum_multi.sv
// Multi-channel Z80 I/O DAC latch with per-channel paced FIFOs and a status/control port.
// Define SPECDRUM_MULTI_MIX_EN to build the registered channel-sum output mix_out.
module specdrum_multi #(
  parameter int         CHANNELS  = 2,
  parameter logic [7:0] BASE_PORT = 8'hDF,
  parameter logic [7:0] CTRL_PORT = 8'hDE,
  parameter int         DEPTH     = 16,
  parameter int         DIV       = 1250
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       a,
  input  logic                             iorq_n,
  input  logic                             wr_n,
  input  logic                             rd_n,
  input  logic [7:0]                       d,
  output logic [7:0]                       dout,
  output logic                             oe,
  output logic [8*CHANNELS-1:0]            ch_out,
  output logic [8+$clog2(CHANNELS)-1:0]    mix_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DIV);
  localparam int MW = 8 + $clog2(CHANNELS);

  logic          wr_act, rd_act, wr_act_q, rd_act_q, wr_stb, rd_stb;
  logic          ctrl_wr, ctrl_rd, flush, tick;
  logic          mode_q, mode_d, overrun_q, overrun_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    ch_off, status;
  logic [3:0]    full4;
  logic [CHANNELS-1:0] full_v, empty_v, ovr_v;

  assign wr_act  = !iorq_n && !wr_n;
  assign rd_act  = !iorq_n && !rd_n;
  assign wr_stb  = wr_act && !wr_act_q;
  assign rd_stb  = rd_act && !rd_act_q;
  assign ctrl_wr = wr_stb && (a == CTRL_PORT);
  assign ctrl_rd = rd_stb && (a == CTRL_PORT);
  assign ch_off  = a - BASE_PORT;
  // Clearing paced mode always discards queued samples.
  assign flush   = ctrl_wr && (d[1] || !d[0]);
  assign tick    = (div_q == DW'(DIV - 1));

  always_comb begin
    mode_d    = mode_q;
    overrun_d = overrun_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    if (ctrl_wr) mode_d = d[0];
    if (ctrl_rd) overrun_d = 1'b0;
    if (|ovr_v)  overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      mode_q    <= 1'b0;
      overrun_q <= 1'b0;
      div_q     <= '0;
    end else begin
      wr_act_q  <= wr_act;
      rd_act_q  <= rd_act;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
      div_q     <= div_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [7:0]    ch_q, ch_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem [DEPTH];
    logic          hit, push, pop, is_full, is_empty;

    assign hit      = wr_stb && (ch_off == 8'(gi));
    assign is_full  = (cnt_q == CW'(DEPTH));
    assign is_empty = (cnt_q == '0);
    assign pop      = tick && mode_q && !is_empty && !flush;
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push     = hit && mode_q && (!is_full || pop) && !flush;
    assign ovr_v[gi]   = hit && mode_q && is_full && !pop && !flush;
    assign full_v[gi]  = is_full;
    assign empty_v[gi] = is_empty;
    assign ch_out[8*gi +: 8] = ch_q;

    always_comb begin
      ch_d  = ch_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
        wp_d  = '0;
        rp_d  = '0;
        cnt_d = '0;
      end else begin
        if (hit && !mode_q) ch_d = d;
        if (pop) begin
          ch_d = mem[rp_q];
          rp_d = rp_q + 1'b1;
        end
        if (push) wp_d = wp_q + 1'b1;
        case ({push, pop})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ch_q  <= '0;
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        ch_q  <= ch_d;
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wp_q] <= d;
    end
  end

  always_comb begin
    full4 = '0;
    full4[CHANNELS-1:0] = full_v;
  end

  assign status = {mode_q, overrun_q, 1'b0, &empty_v, full4};
  assign oe     = rd_act && (a == CTRL_PORT);
  assign dout   = oe ? status : 8'h00;

`ifdef SPECDRUM_MULTI_MIX_EN
  logic [MW-1:0] mix_q, mix_d;

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < CHANNELS; i++) mix_d = mix_d + MW'(ch_out[8*i +: 8]);
  end

  always_ff @(posedge clk) begin
    if (rst) mix_q <= '0;
    else     mix_q <= mix_d;
  end

  assign mix_out = mix_q;
`else
  assign mix_out = '0;
`endif
endmodule

// File: tb/tb_specdrum_multi.sv
// Directed self-checking bench for specdrum_multi (2 channels, 16-deep FIFOs, short divider).
// Mix expectations follow SPECDRUM_MULTI_MIX_EN as seen by this compile.
module tb_specdrum_multi;
  localparam int CH    = 2;
  localparam int DEPTH = 16;
  localparam int DIV   = 64;
`ifdef SPECDRUM_MULTI_MIX_EN
  localparam logic [8:0] MIX_MID = 9'h176;
  localparam logic [8:0] MIX_FF  = 9'h1FE;
`else
  localparam logic [8:0] MIX_MID = 9'h000;
  localparam logic [8:0] MIX_FF  = 9'h000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a, d, dout;
  logic        iorq_n, wr_n, rd_n, oe;
  logic [15:0] ch_out;
  logic [8:0]  mix_out;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          div_m   = 0;

  specdrum_multi #(
    .CHANNELS(CH), .BASE_PORT(8'hDF), .CTRL_PORT(8'hDE), .DEPTH(DEPTH), .DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .wr_n(wr_n), .rd_n(rd_n),
    .d(d), .dout(dout), .oe(oe), .ch_out(ch_out), .mix_out(mix_out)
  );

  always #5 clk = ~clk;

  // Reference sample divider: a tick happens on the edge where div_m == DIV-1.
  always @(posedge clk) begin
    if (rst) div_m <= 0;
    else     div_m <= (div_m == DIV - 1) ? 0 : div_m + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s val=%0h", tag, got);
    end
  endtask

  // Bus write of one cycle; starts and ends at a negedge.
  task automatic io_wr(input logic [7:0] addr, input logic [7:0] data);
    a = addr; d = data; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd_stat(input string tag, input logic [7:0] exp);
    a = 8'hDE; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check({tag, "_oe"}, 32'(oe), 32'd1);
    check(tag, 32'(dout), 32'(exp));
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_div(input int v);
    int n = 0;
    @(negedge clk);
    while (div_m != v && n < 2 * DIV) begin
      @(negedge clk);
      n++;
    end
    if (div_m != v) check("div_align_timeout", 32'(div_m), 32'(v));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tick_exp [3];
    tick_exp[0] = 8'd10; tick_exp[1] = 8'd20; tick_exp[2] = 8'd30;
    rst = 1'b1; a = 8'h00; d = 8'h00; iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ch_out", 32'(ch_out), 32'h0);
    check("rst_mix", 32'(mix_out), 32'h0);
    check("rst_oe", 32'(oe), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd_stat("rst_status", 8'h10);

    // Direct write held 4 cycles: updates on the first edge only.
    a = 8'hDF; d = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    check("direct_ch0_first_edge", 32'(ch_out[7:0]), 32'h5A);
    check("direct_ch1_zero", 32'(ch_out[15:8]), 32'h00);
    @(negedge clk);
    d = 8'hA5;
    repeat (3) @(negedge clk);
    check("direct_single_update", 32'(ch_out), 32'h005A);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);

    io_wr(8'h50, 8'h33);
    io_wr(8'hE1, 8'h44);
    check("unmapped_ignored", 32'(ch_out), 32'h005A);

    a = 8'hDF; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("rd_other_oe", 32'(oe), 32'h0);
    check("rd_other_dout", 32'(dout), 32'h0);
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);

    // Paced mode: three pushes to channel 1 emerge one per tick.
    io_wr(8'hDE, 8'h01);
    rd_stat("paced_status", 8'h90);
    wait_div(0);
    io_wr(8'hE0, 8'd10);
    io_wr(8'hE0, 8'd20);
    io_wr(8'hE0, 8'd30);
    for (int k = 0; k < 3; k++) begin
      wait_div(DIV - 1);
      check($sformatf("pre_tick%0d_ch1", k), 32'(ch_out[15:8]), k == 0 ? 32'd0 : 32'(tick_exp[k-1]));
      @(posedge clk); #1;
      check($sformatf("tick%0d_ch1", k), 32'(ch_out[15:8]), 32'(tick_exp[k]));
    end
    @(negedge clk);
    repeat (2 * DIV) @(negedge clk);
    check("paced_hold_ch1", 32'(ch_out[15:8]), 32'd30);
    check("paced_ch0_untouched", 32'(ch_out[7:0]), 32'h5A);
    rd_stat("drained_status", 8'h90);

    // Overflow channel 0 between ticks.
    wait_div(0);
    for (int i = 1; i <= DEPTH + 1; i++) io_wr(8'hDF, 8'(i));
    rd_stat("ovr_status_first", 8'hC1);
    rd_stat("ovr_status_second", 8'h81);

    // Push into a full FIFO on the tick edge.
    wait_div(DIV - 1);
    a = 8'hDF; d = 8'hEE; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    check("tick_pop_head", 32'(ch_out[7:0]), 32'h01);
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    rd_stat("push_full_tick_status", 8'h81);
    repeat (17 * DIV) @(negedge clk);
    check("full_push_accepted_tail", 32'(ch_out[7:0]), 32'hEE);
    rd_stat("drain_status", 8'h90);

    // Flush issued on a tick edge: queues cleared, outputs untouched.
    wait_div(0);
    for (int i = 0; i < 3; i++) begin
      io_wr(8'hDF, 8'h41);
      io_wr(8'hE0, 8'h42);
    end
    wait_div(DIV - 1);
    io_wr(8'hDE, 8'h03);
    check("flush_vs_tick", 32'(ch_out), 32'h1EEE);
    rd_stat("flush_status", 8'h90);
    repeat (2 * DIV) @(negedge clk);
    check("flush_hold", 32'(ch_out), 32'h1EEE);
    io_wr(8'hDE, 8'h00);
    rd_stat("direct_restored_status", 8'h10);
    io_wr(8'hE0, 8'h77);
    check("direct_restored_ch1", 32'(ch_out), 32'h77EE);

    // Mixer latency, then reset mid-stream.
    io_wr(8'hDF, 8'hFF);
    a = 8'hE0; d = 8'hFF; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    check("mix_ch_ff", 32'(ch_out), 32'hFFFF);
    check("mix_before", 32'(mix_out), 32'(MIX_MID));
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
    check("mix_after", 32'(mix_out), 32'(MIX_FF));
    @(negedge clk);
    io_wr(8'hDE, 8'h01);
    io_wr(8'hDF, 8'h12);
    io_wr(8'hE0, 8'h34);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ch_out", 32'(ch_out), 32'h0);
    check("midrst_mix", 32'(mix_out), 32'h0);
    check("midrst_oe", 32'(oe), 32'h0);
    check("midrst_dout", 32'(dout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_stat("post_rst_status", 8'h10);
    repeat (2 * DIV) @(negedge clk);
    check("post_rst_queue_lost", 32'(ch_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
